// File: rtl/cpu_pkg.sv
// MCS8 CPU shared definitions: fetch state encoding,
// address width and reset defaults.
package cpu_pkg;

  localparam int          PC_W_DEF   = 14;
  localparam logic [13:0] RST_PC_DEF = 14'h0000;
  localparam logic [7:0]  OP_NOP     = 8'h00;

  typedef enum logic [2:0] {
    FETCH_OP = 3'd0,
    LEN      = 3'd1,
    FETCH_B2 = 3'd2,
    FETCH_B3 = 3'd3,
    HOLD     = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/cpu_fetch.sv
// MCS8 instruction fetch: reads 1-3 instruction bytes,
// holds them for execute and owns the program counter.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W   = PC_W_DEF,
  parameter logic [PC_W-1:0] RST_PC = PC_W'(RST_PC_DEF)
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  output logic            MEM_REQ_O,
  output logic [PC_W-1:0] MEM_ADDR_O,
  input  logic            MEM_ACK_I,
  input  logic [7:0]      MEM_DATA_I,
  output logic [7:0]      IR_O,
  input  logic            D_SRC_I_I,
  input  logic            D_JUMP_I,
  input  logic            D_CALL_I,
  output logic [7:0]      IMM_LO_O,
  output logic [7:0]      IMM_HI_O,
  output logic [PC_W-1:0] PC_O,
  output logic            INSTR_VLD_O,
  input  logic            INSTR_RDY_I,
  input  logic            PC_LD_I,
  input  logic [PC_W-1:0] PC_LD_VAL_I
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      imm_lo_q, imm_lo_d;
  logic [7:0]      imm_hi_q, imm_hi_d;
  logic            need3_q, need3_d;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imm_lo_d = imm_lo_q;
    imm_hi_d = imm_hi_q;
    need3_d  = need3_q;
    case (state_q)
      FETCH_OP: begin
        if (MEM_ACK_I) begin
          ir_d     = MEM_DATA_I;
          imm_lo_d = 8'h00;
          imm_hi_d = 8'h00;
          pc_d     = pc_inc;
          state_d  = LEN;
        end
      end
      LEN: begin
        // decoder flags reflect ir_q only in this cycle
        if (D_JUMP_I || D_CALL_I) begin
          need3_d = 1'b1;
          state_d = FETCH_B2;
        end else if (D_SRC_I_I) begin
          need3_d = 1'b0;
          state_d = FETCH_B2;
        end else begin
          state_d = HOLD;
        end
      end
      FETCH_B2: begin
        if (MEM_ACK_I) begin
          imm_lo_d = MEM_DATA_I;
          pc_d     = pc_inc;
          state_d  = need3_q ? FETCH_B3 : HOLD;
        end
      end
      FETCH_B3: begin
        if (MEM_ACK_I) begin
          imm_hi_d = MEM_DATA_I;
          pc_d     = pc_inc;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (INSTR_RDY_I) begin
          state_d = FETCH_OP;
          if (PC_LD_I) pc_d = PC_LD_VAL_I;
        end
      end
      default: state_d = FETCH_OP;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= FETCH_OP;
      pc_q     <= RST_PC;
      ir_q     <= OP_NOP;
      imm_lo_q <= 8'h00;
      imm_hi_q <= 8'h00;
      need3_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      imm_lo_q <= imm_lo_d;
      imm_hi_q <= imm_hi_d;
      need3_q  <= need3_d;
    end
  end

  assign MEM_REQ_O   = (state_q == FETCH_OP) ||
                       (state_q == FETCH_B2) ||
                       (state_q == FETCH_B3);
  assign INSTR_VLD_O = (state_q == HOLD);
  assign MEM_ADDR_O  = pc_q;
  assign PC_O        = pc_q;
  assign IR_O        = ir_q;
  assign IMM_LO_O    = imm_lo_q;
  assign IMM_HI_O    = imm_hi_q;

endmodule
